instruction_fetch_unit: RTL and testbench

Instruction fetch stage of the pipelined MIPS datapath: holds the program counter, drives the instruction memory address, and captures the returned word into the IF/ID pipeline register. Its registered opcode output drives the control unit's `OperationCode` input directly. It accepts redirects (taken BNE, J) and stall/flush requests from the decode stage, and keeps a count of valid fetched instructions for simulation statistics.

---
 rtl/instruction_fetch_unit.sv | 89 ++++++++
 tb/tb_instruction_fetch_unit.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// IF stage: PC register, instruction-memory address and IF/ID pipeline register; fetch latency 1 edge.
// Stall freezes the PC and IF/ID, Flush/redirect insert a bubble, and InstructionCount tallies valid IF/ID loads.
module instruction_fetch_unit #(
  parameter logic [31:0] ResetVector = 32'h0000_0000
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Stall,
  input  logic        Flush,
  input  logic        BranchTaken,
  input  logic [31:0] BranchOffset,
  input  logic        Jump,
  input  logic [25:0] JumpField,
  output logic [31:0] InstructionAddress,
  input  logic [31:0] InstructionWord,
  output logic [31:0] FetchedInstruction,
  output logic [31:0] FetchedPCPlus4,
  output logic [5:0]  OperationCode,
  output logic        FetchedValid,
  output logic [31:0] InstructionCount
);

  logic [31:0] r_pc;
  logic [31:0] r_ifid_instr;
  logic [31:0] r_ifid_pc4;
  logic        r_ifid_vld;
  logic [31:0] r_count;

  logic [31:0] w_pc_plus4;
  logic [31:0] w_jump_target;
  logic [31:0] w_branch_sum;
  logic [31:0] w_branch_target;
  logic [31:0] w_pc_next;
  logic        w_redirect;
  logic        w_unused;

  assign w_pc_plus4      = r_pc + 32'd4;
  assign w_jump_target   = {r_ifid_pc4[31:28], JumpField, 2'b00};
  assign w_branch_sum    = r_ifid_pc4 + (BranchOffset << 2);
  assign w_branch_target = {w_branch_sum[31:2], 2'b00};
  assign w_redirect      = Jump | BranchTaken;
  assign w_unused        = &{1'b0, w_branch_sum[1:0]};

  // Jump outranks BranchTaken; both are ignored while stalled so ID re-presents them later.
  always_comb begin
    w_pc_next = w_pc_plus4;
    if (Stall)
      w_pc_next = r_pc;
    else if (Jump)
      w_pc_next = w_jump_target;
    else if (BranchTaken)
      w_pc_next = w_branch_target;
  end

  always_ff @(posedge Clock) begin
    if (Reset)
      r_pc <= ResetVector;
    else
      r_pc <= w_pc_next;
  end

  // Flush wins over Stall so a held bad instruction can still be squashed.
  always_ff @(posedge Clock) begin
    if (Reset || Flush || (!Stall && w_redirect)) begin
      r_ifid_instr <= 32'h0000_0000;
      r_ifid_pc4   <= 32'h0000_0000;
      r_ifid_vld   <= 1'b0;
    end else if (!Stall) begin
      r_ifid_instr <= InstructionWord;
      r_ifid_pc4   <= w_pc_plus4;
      r_ifid_vld   <= 1'b1;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset)
      r_count <= 32'd0;
    else if (!Flush && !Stall && !w_redirect)
      r_count <= r_count + 32'd1;
  end

  assign InstructionAddress = r_pc;
  assign FetchedInstruction = r_ifid_instr;
  assign FetchedPCPlus4     = r_ifid_pc4;
  assign OperationCode      = r_ifid_instr[31:26];
  assign FetchedValid       = r_ifid_vld;
  assign InstructionCount   = r_count;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit; memory returns address ^ 32'hA5A5_0000.
module tb_instruction_fetch_unit;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        Stall = 1'b0;
  logic        Flush = 1'b0;
  logic        BranchTaken = 1'b0;
  logic [31:0] BranchOffset = 32'h0;
  logic        Jump = 1'b0;
  logic [25:0] JumpField = 26'h0;
  logic [31:0] InstructionAddress;
  logic [31:0] InstructionWord;
  logic [31:0] FetchedInstruction;
  logic [31:0] FetchedPCPlus4;
  logic [5:0]  OperationCode;
  logic        FetchedValid;
  logic [31:0] InstructionCount;

  int compared = 0;
  int failed   = 0;

  instruction_fetch_unit #(.ResetVector(32'h0000_0000)) dut (
    .Clock(Clock), .Reset(Reset), .Stall(Stall), .Flush(Flush),
    .BranchTaken(BranchTaken), .BranchOffset(BranchOffset),
    .Jump(Jump), .JumpField(JumpField),
    .InstructionAddress(InstructionAddress), .InstructionWord(InstructionWord),
    .FetchedInstruction(FetchedInstruction), .FetchedPCPlus4(FetchedPCPlus4),
    .OperationCode(OperationCode), .FetchedValid(FetchedValid),
    .InstructionCount(InstructionCount)
  );

  always #5 Clock = ~Clock;
  assign InstructionWord = InstructionAddress ^ 32'hA5A5_0000;

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    compared++; if (InstructionAddress !== 32'h0) begin failed++; $display("FAIL rst_addr: got %h want %h", InstructionAddress, 32'h0); end
    compared++; if (FetchedInstruction !== 32'h0) begin failed++; $display("FAIL rst_instr: got %h want %h", FetchedInstruction, 32'h0); end
    compared++; if (FetchedPCPlus4 !== 32'h0) begin failed++; $display("FAIL rst_pc4: got %h want %h", FetchedPCPlus4, 32'h0); end
    compared++; if (OperationCode !== 6'h0) begin failed++; $display("FAIL rst_op: got %h want %h", OperationCode, 6'h0); end
    compared++; if (FetchedValid !== 1'b0) begin failed++; $display("FAIL rst_vld: got %b want 0", FetchedValid); end
    compared++; if (InstructionCount !== 32'd0) begin failed++; $display("FAIL rst_cnt: got %0d want 0", InstructionCount); end
  endtask

  task automatic test_sequential();
    for (int i = 1; i <= 3; i++) begin
      logic [31:0] a;
      step();
      a = 32'(4 * i);
      compared++; if (InstructionAddress !== a) begin failed++; $display("FAIL seq_addr%0d: got %h want %h", i, InstructionAddress, a); end
      compared++; if (FetchedPCPlus4 !== a) begin failed++; $display("FAIL seq_pc4_%0d: got %h want %h", i, FetchedPCPlus4, a); end
      compared++; if (FetchedInstruction !== ((a - 32'd4) ^ 32'hA5A5_0000)) begin failed++; $display("FAIL seq_instr%0d: got %h want %h", i, FetchedInstruction, (a - 32'd4) ^ 32'hA5A5_0000); end
      compared++; if (FetchedValid !== 1'b1) begin failed++; $display("FAIL seq_vld%0d: got %b want 1", i, FetchedValid); end
    end
    compared++; if (OperationCode !== 6'h29) begin failed++; $display("FAIL seq_op: got %h want %h", OperationCode, 6'h29); end
    compared++; if (InstructionCount !== 32'd3) begin failed++; $display("FAIL seq_cnt: got %0d want 3", InstructionCount); end
  endtask

  task automatic test_jump();
    step();  // IF/ID now holds the word from 0xC, PC+4 = 0x10
    compared++; if (FetchedPCPlus4 !== 32'h10) begin failed++; $display("FAIL jmp_setup_pc4: got %h want %h", FetchedPCPlus4, 32'h10); end
    Jump = 1'b1; JumpField = 26'h000_0040;
    step();
    Jump = 1'b0;
    compared++; if (InstructionAddress !== 32'h100) begin failed++; $display("FAIL jmp_addr: got %h want %h", InstructionAddress, 32'h100); end
    compared++; if (FetchedValid !== 1'b0) begin failed++; $display("FAIL jmp_bubble_vld: got %b want 0", FetchedValid); end
    compared++; if (OperationCode !== 6'h0) begin failed++; $display("FAIL jmp_bubble_op: got %h want %h", OperationCode, 6'h0); end
    compared++; if (InstructionCount !== 32'd4) begin failed++; $display("FAIL jmp_bubble_cnt: got %0d want 4", InstructionCount); end
    step();
    compared++; if (FetchedInstruction !== 32'hA5A5_0100) begin failed++; $display("FAIL jmp_target_instr: got %h want %h", FetchedInstruction, 32'hA5A5_0100); end
    compared++; if (FetchedPCPlus4 !== 32'h104) begin failed++; $display("FAIL jmp_target_pc4: got %h want %h", FetchedPCPlus4, 32'h104); end
    compared++; if (InstructionCount !== 32'd5) begin failed++; $display("FAIL jmp_target_cnt: got %0d want 5", InstructionCount); end
  endtask

  task automatic test_branch();
    Jump = 1'b1; JumpField = 26'h000_0007;  // land at 0x1C so IF/ID PC+4 becomes 0x20
    step();
    Jump = 1'b0;
    step();
    compared++; if (FetchedPCPlus4 !== 32'h20) begin failed++; $display("FAIL br_setup_pc4: got %h want %h", FetchedPCPlus4, 32'h20); end
    BranchTaken = 1'b1; BranchOffset = 32'hFFFF_FFFE;
    step();
    BranchTaken = 1'b0;
    compared++; if (InstructionAddress !== 32'h18) begin failed++; $display("FAIL br_addr: got %h want %h", InstructionAddress, 32'h18); end
    compared++; if (FetchedValid !== 1'b0) begin failed++; $display("FAIL br_bubble_vld: got %b want 0", FetchedValid); end
    step();
    compared++; if (FetchedInstruction !== 32'hA5A5_0018) begin failed++; $display("FAIL br_target_instr: got %h want %h", FetchedInstruction, 32'hA5A5_0018); end
    compared++; if (InstructionCount !== 32'd7) begin failed++; $display("FAIL br_cnt: got %0d want 7", InstructionCount); end
  endtask

  task automatic test_stall_branch();
    Stall = 1'b1; BranchTaken = 1'b1; BranchOffset = 32'h0000_0004;
    for (int i = 0; i < 3; i++) begin
      step();
      compared++; if (InstructionAddress !== 32'h1C) begin failed++; $display("FAIL stall_addr%0d: got %h want %h", i, InstructionAddress, 32'h1C); end
      compared++; if (FetchedInstruction !== 32'hA5A5_0018) begin failed++; $display("FAIL stall_instr%0d: got %h want %h", i, FetchedInstruction, 32'hA5A5_0018); end
      compared++; if (FetchedPCPlus4 !== 32'h1C) begin failed++; $display("FAIL stall_pc4_%0d: got %h want %h", i, FetchedPCPlus4, 32'h1C); end
      compared++; if (InstructionCount !== 32'd7) begin failed++; $display("FAIL stall_cnt%0d: got %0d want 7", i, InstructionCount); end
    end
    Stall = 1'b0;
    step();
    BranchTaken = 1'b0;
    compared++; if (InstructionAddress !== 32'h2C) begin failed++; $display("FAIL stall_rel_addr: got %h want %h", InstructionAddress, 32'h2C); end
    compared++; if (FetchedValid !== 1'b0) begin failed++; $display("FAIL stall_rel_vld: got %b want 0", FetchedValid); end
    step();
    compared++; if (InstructionAddress !== 32'h30) begin failed++; $display("FAIL stall_once_addr: got %h want %h", InstructionAddress, 32'h30); end
    compared++; if (FetchedInstruction !== 32'hA5A5_002C) begin failed++; $display("FAIL stall_once_instr: got %h want %h", FetchedInstruction, 32'hA5A5_002C); end
    compared++; if (InstructionCount !== 32'd8) begin failed++; $display("FAIL stall_once_cnt: got %0d want 8", InstructionCount); end
  endtask

  task automatic test_flush();
    Flush = 1'b1; Stall = 1'b1;
    step();
    compared++; if (InstructionAddress !== 32'h30) begin failed++; $display("FAIL flst_addr: got %h want %h", InstructionAddress, 32'h30); end
    compared++; if (FetchedValid !== 1'b0) begin failed++; $display("FAIL flst_vld: got %b want 0", FetchedValid); end
    compared++; if (FetchedInstruction !== 32'h0) begin failed++; $display("FAIL flst_instr: got %h want %h", FetchedInstruction, 32'h0); end
    compared++; if (FetchedPCPlus4 !== 32'h0) begin failed++; $display("FAIL flst_pc4: got %h want %h", FetchedPCPlus4, 32'h0); end
    Stall = 1'b0;
    step();
    Flush = 1'b0;
    compared++; if (InstructionAddress !== 32'h34) begin failed++; $display("FAIL fl_addr: got %h want %h", InstructionAddress, 32'h34); end
    compared++; if (FetchedValid !== 1'b0) begin failed++; $display("FAIL fl_vld: got %b want 0", FetchedValid); end
    compared++; if (InstructionCount !== 32'd8) begin failed++; $display("FAIL fl_cnt: got %0d want 8", InstructionCount); end
    step();
    compared++; if (FetchedInstruction !== 32'hA5A5_0034) begin failed++; $display("FAIL fl_after_instr: got %h want %h", FetchedInstruction, 32'hA5A5_0034); end
    compared++; if (InstructionCount !== 32'd9) begin failed++; $display("FAIL fl_after_cnt: got %0d want 9", InstructionCount); end
  endtask

  task automatic test_wrap();
    BranchTaken = 1'b1; BranchOffset = 32'hFFFF_FFF1;  // 0x38 + 0xFFFFFFC4 = 0xFFFFFFFC
    step();
    BranchTaken = 1'b0;
    compared++; if (InstructionAddress !== 32'hFFFF_FFFC) begin failed++; $display("FAIL wrap_setup_addr: got %h want %h", InstructionAddress, 32'hFFFF_FFFC); end
    step();
    compared++; if (InstructionAddress !== 32'h0) begin failed++; $display("FAIL wrap_addr: got %h want %h", InstructionAddress, 32'h0); end
    compared++; if (FetchedPCPlus4 !== 32'h0) begin failed++; $display("FAIL wrap_pc4: got %h want %h", FetchedPCPlus4, 32'h0); end
    compared++; if (FetchedInstruction !== 32'h5A5A_FFFC) begin failed++; $display("FAIL wrap_instr: got %h want %h", FetchedInstruction, 32'h5A5A_FFFC); end
    compared++; if (OperationCode !== 6'h16) begin failed++; $display("FAIL wrap_op: got %h want %h", OperationCode, 6'h16); end
    compared++; if (InstructionCount !== 32'd10) begin failed++; $display("FAIL wrap_cnt: got %0d want 10", InstructionCount); end
  endtask

  task automatic test_reset_mid_stall();
    Stall = 1'b1;
    step();
    Flush = 1'b1; Jump = 1'b1; JumpField = 26'h000_0040; Reset = 1'b1;
    step();
    Reset = 1'b0; Stall = 1'b0; Flush = 1'b0; Jump = 1'b0;
    compared++; if (InstructionAddress !== 32'h0) begin failed++; $display("FAIL mrst_addr: got %h want %h", InstructionAddress, 32'h0); end
    compared++; if (FetchedInstruction !== 32'h0) begin failed++; $display("FAIL mrst_instr: got %h want %h", FetchedInstruction, 32'h0); end
    compared++; if (FetchedValid !== 1'b0) begin failed++; $display("FAIL mrst_vld: got %b want 0", FetchedValid); end
    compared++; if (InstructionCount !== 32'd0) begin failed++; $display("FAIL mrst_cnt: got %0d want 0", InstructionCount); end
    step();
    compared++; if (FetchedPCPlus4 !== 32'h4) begin failed++; $display("FAIL mrst_resume_pc4: got %h want %h", FetchedPCPlus4, 32'h4); end
    compared++; if (InstructionCount !== 32'd1) begin failed++; $display("FAIL mrst_resume_cnt: got %0d want 1", InstructionCount); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_jump();
    test_branch();
    test_stall_branch();
    test_flush();
    test_wrap();
    test_reset_mid_stall();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
